// File: rtl/mem_addr_sel_ctl_pkg.sv
// Shared types and encodings for the memory address source selector.
// Also used by the load/store unit for access-size decoding.
package mem_addr_sel_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_EXC  = 2'b10
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_SEL     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

endpackage

// File: rtl/mem_addr_sel_ctl_align_chk.sv
// Combinational alignment check: flags misaligned halfword/word accesses
// and the reserved access size.
module mem_align_chk
    import mem_addr_sel_ctl_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [1:0] acc_size,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (acc_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = (addr_lo != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_addr_sel_ctl.sv
// Latches one of N_SRC address sources on start, validates it, and holds
// address and request toward memory until acknowledged or timed out.
module mem_addr_sel_ctl
    import mem_addr_sel_ctl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_SRC   = 4,
    parameter int SEL_W   = $clog2(N_SRC),
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*WIDTH-1:0] src_addr,
    input  logic [1:0]             acc_size,
    input  logic                   mem_ready,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       addr_out,
    output logic                   mem_req,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output state_t                 dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sel_addr;
    logic             sel_oor;
    logic             misaligned;
    logic [CNT_W-1:0] wait_cnt;

    // Out-of-range selectors fall through to a zero address.
    always_comb begin
        sel_addr = '0;
        sel_oor  = 1'b1;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_addr = src_addr[i*WIDTH +: WIDTH];
                sel_oor  = 1'b0;
            end
        end
    end

    mem_align_chk u_align_chk (
        .addr_lo    (sel_addr[1:0]),
        .acc_size   (acc_size),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Handshake: mem_req is valid, mem_ready is ready; a transfer completes
    // in the cycle both are high, and addr_out is stable while mem_req is high.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = (sel_oor || misaligned) ? ST_EXC : ST_REQ;
            ST_REQ: begin
                if (mem_ready)             state_next = ST_IDLE;
                else if (wait_cnt == CNT_LAST) state_next = ST_EXC;
            end
            ST_EXC:  if (err_clr) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state == ST_REQ);
        busy      = (state != ST_IDLE);
        err       = (state == ST_EXC);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_out <= '0;
            done     <= 1'b0;
            err_code <= ERR_NONE;
            wait_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_out <= sel_addr;
                        wait_cnt <= '0;
                        if (sel_oor)         err_code <= ERR_SEL;
                        else if (misaligned) err_code <= ERR_ALIGN;
                        else                 err_code <= ERR_NONE;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        done     <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        // Stops at TIMEOUT because the FSM leaves REQ there.
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_LAST) err_code <= ERR_TIMEOUT;
                    end
                end
                ST_EXC: begin
                    if (err_clr) begin
                        err_code <= ERR_NONE;
                        wait_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_addr_sel_ctl.sv
// Directed bench for mem_addr_sel_ctl with N_SRC=3, TIMEOUT=4.
module tb_mem_addr_sel_ctl;
    import mem_addr_sel_ctl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int N_SRC   = 3;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 4;

    logic                   clk;
    logic                   reset_n;
    logic                   start;
    logic [SEL_W-1:0]       sel;
    logic [N_SRC*WIDTH-1:0] src_addr;
    logic [1:0]             acc_size;
    logic                   mem_ready;
    logic                   err_clr;
    logic [WIDTH-1:0]       addr_out;
    logic                   mem_req;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [1:0]             err_code;
    state_t                 dbg_state;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    mem_addr_sel_ctl #(
        .WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sel(sel),
        .src_addr(src_addr), .acc_size(acc_size), .mem_ready(mem_ready),
        .err_clr(err_clr), .addr_out(addr_out), .mem_req(mem_req),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_srcs(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                            input logic [WIDTH-1:0] s2);
        src_addr = {s2, s1, s0};
    endtask

    // Pulse start for one cycle; returns positioned in the cycle after the edge.
    task automatic issue(input logic [SEL_W-1:0] s, input logic [1:0] sz);
        sel = s; acc_size = sz; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 0; sel = 0; acc_size = SIZE_WORD;
        mem_ready = 0; err_clr = 0; set_srcs(32'h0, 32'h0, 32'h0);
        #12;
        checks++;
        if ({addr_out, mem_req, busy, done, err, err_code} !== {32'h0, 6'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h req=%b busy=%b done=%b err=%b code=%b required all zero",
                     addr_out, mem_req, busy, done, err, err_code);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_transfer();
        set_srcs(32'h0000_0010, 32'h0000_0040, 32'h0000_0080);
        issue(2'd1, SIZE_WORD);
        checks++;
        if ({addr_out, mem_req, busy, done} !== {32'h40, 3'b110}) begin
            errors++;
            $display("FAIL transfer_req: got addr=%h req=%b busy=%b done=%b required 40/1/1/0",
                     addr_out, mem_req, busy, done);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({done, mem_req, busy, err} !== 4'b1000) begin
            errors++;
            $display("FAIL transfer_done: got done=%b req=%b busy=%b err=%b required 1/0/0/0",
                     done, mem_req, busy, err);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL transfer_after: got done=%b busy=%b required 0/0", done, busy);
        end
        // Byte access at an odd address is legal.
        set_srcs(32'h0000_0043, 32'h0, 32'h0);
        issue(2'd0, SIZE_BYTE);
        checks++;
        if ({addr_out, mem_req, err} !== {32'h43, 2'b10}) begin
            errors++;
            $display("FAIL byte_odd: got addr=%h req=%b err=%b required 43/1/0", addr_out, mem_req, err);
        end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick();
    endtask

    task automatic test_misaligned();
        int req_seen;
        set_srcs(32'h0000_0042, 32'h0000_0041, 32'h0000_0042);
        issue(2'd0, SIZE_WORD);
        req_seen = 0;
        checks++;
        if ({err, err_code, addr_out, busy} !== {1'b1, ERR_ALIGN, 32'h42, 1'b1}) begin
            errors++;
            $display("FAIL word_misaligned: got err=%b code=%b addr=%h busy=%b required 1/01/42/1",
                     err, err_code, addr_out, busy);
        end
        // start and mem_ready are ignored in EXC.
        start = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) req_seen++;
            tick();
        end
        start = 1'b0; mem_ready = 1'b0;
        checks++;
        if (req_seen !== 0 || err !== 1'b1 || err_code !== ERR_ALIGN) begin
            errors++;
            $display("FAIL exc_hold: got req_cycles=%0d err=%b code=%b required 0/1/01",
                     req_seen, err, err_code);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++;
        if ({err, err_code, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL err_clr: got err=%b code=%b busy=%b required 0/00/0", err, err_code, busy);
        end
        issue(2'd1, SIZE_HALF);
        checks++;
        if ({err_code, addr_out} !== {ERR_ALIGN, 32'h41}) begin
            errors++;
            $display("FAIL half_misaligned: got code=%b addr=%h required 01/41", err_code, addr_out);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        issue(2'd2, SIZE_RSVD);
        checks++;
        if ({err, err_code} !== {1'b1, ERR_ALIGN}) begin
            errors++;
            $display("FAIL reserved_size: got err=%b code=%b required 1/01", err, err_code);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        issue(2'd2, SIZE_HALF);
        checks++;
        if ({err, mem_req, addr_out} !== {2'b01, 32'h42}) begin
            errors++;
            $display("FAIL half_aligned: got err=%b req=%b addr=%h required 0/1/42", err, mem_req, addr_out);
        end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick();
    endtask

    task automatic test_sel_range();
        set_srcs(32'h11, 32'h22, 32'h33);
        issue(2'd3, SIZE_WORD);
        checks++;
        if ({err, err_code, addr_out, mem_req} !== {1'b1, ERR_SEL, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL sel_range: got err=%b code=%b addr=%h req=%b required 1/10/0/0",
                     err, err_code, addr_out, mem_req);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        // Selector range outranks the reserved-size error.
        issue(2'd3, SIZE_RSVD);
        checks++;
        if (err_code !== ERR_SEL) begin
            errors++;
            $display("FAIL sel_priority: got code=%b required 10", err_code);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cycles;
        set_srcs(32'h100, 32'h0, 32'h0);
        issue(2'd0, SIZE_WORD);
        req_cycles = 0;
        for (int i = 0; i < 10 && mem_req; i++) begin
            req_cycles++;
            tick();
        end
        checks++;
        if (req_cycles !== TIMEOUT || err !== 1'b1 || err_code !== ERR_TIMEOUT || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got req_cycles=%0d err=%b code=%b req=%b required 4/1/11/0",
                     req_cycles, err, err_code, mem_req);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        issue(2'd0, SIZE_WORD);
        tick(); tick(); tick();
        mem_ready = 1'b1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_4th_req: got req=%b required 1", mem_req);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({done, err, err_code, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL ready_wins: got done=%b err=%b code=%b busy=%b required 1/0/00/0",
                     done, err, err_code, busy);
        end
        tick();
    endtask

    task automatic test_hold();
        set_srcs(32'h200, 32'h300, 32'h400);
        issue(2'd1, SIZE_WORD);
        sel = 2'd2; set_srcs(32'h204, 32'h304, 32'h404); start = 1'b1; err_clr = 1'b1;
        tick();
        start = 1'b0; err_clr = 1'b0;
        checks++;
        if ({addr_out, mem_req, err} !== {32'h300, 2'b10}) begin
            errors++;
            $display("FAIL hold_addr: got addr=%h req=%b err=%b required 300/1/0", addr_out, mem_req, err);
        end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        checks++;
        if ({done, addr_out} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL hold_done: got done=%b addr=%h required 1/300", done, addr_out);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL hold_no_second: got busy=%b done=%b required 0/0", busy, done);
        end
        // mem_ready in IDLE must not produce a done.
        mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_ready: got busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_addr;
        set_srcs(32'h500, 32'h600, 32'h700);
        exp_q.push_back(32'h500);
        exp_q.push_back(32'h700);
        issue(2'd0, SIZE_WORD);
        mem_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            exp_addr = exp_q.pop_front();
            checks++;
            if (addr_out !== exp_addr || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL b2b_addr%0d: got addr=%h req=%b required %h/1", n, addr_out, mem_req, exp_addr);
            end
            tick();
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done%0d: got done=%b required 1", n, done);
            end
            if (n == 0) begin
                mem_ready = 1'b0;
                issue(2'd2, SIZE_WORD);
                mem_ready = 1'b1;
            end
        end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_srcs(32'h800, 32'h0, 32'h0);
        issue(2'd0, SIZE_WORD);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, done, addr_out} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: got req=%b busy=%b done=%b addr=%h required 0/0/0/0",
                     mem_req, busy, done, addr_out);
        end
        mem_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_done: got done=%b busy=%b required 0/0", done, busy);
        end
        issue(2'd0, SIZE_WORD);
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        checks++;
        if ({done, addr_out} !== {1'b1, 32'h800}) begin
            errors++;
            $display("FAIL reset_recover: got done=%b addr=%h required 1/800", done, addr_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_misaligned();
        test_sel_range();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_addr_sel_ctl.md
# mem_addr_sel_ctl

Registered, parametrised memory-address source selector with a request/ready handshake toward memory, sitting between the datapath address sources (PC, ALUOut, ALU result, exception vector, …) and the memory port of the multicycle core. It latches the selected source on a control-unit start pulse, checks alignment and selector range, and holds a stable address and request until memory acknowledges. A bounded wait counter converts a hung memory into an error.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- N_SRC, 4, number of address sources (≥2)
- SEL_W, $clog2(N_SRC), selector width
- TIMEOUT, 15, maximum cycles waiting for mem_ready (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse from control unit: latch and issue
- sel  in  SEL_W  source index, sampled with start
- src_addr  in  N_SRC*WIDTH  packed sources; source i = bits [i*WIDTH +: WIDTH]
- acc_size  in  2  00 byte, 01 half, 10 word, 11 reserved; sampled with start
- mem_ready  in  1  memory accepts/completes current request
- err_clr  in  1  clears error state
- addr_out  out  WIDTH  registered memory address
- mem_req  out  1  request valid to memory
- busy  out  1  block not in IDLE
- done  out  1  one-cycle pulse on completed transfer
- err  out  1  error state active
- err_code  out  2  00 none, 01 misaligned/reserved size, 10 sel out of range, 11 timeout

## Operation
- Decided: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: state IDLE, addr_out 0, mem_req 0, busy 0, done 0, err 0, err_code 00, wait counter 0.
- States: IDLE, REQ, EXC.
- IDLE: on start, evaluate in priority order: sel ≥ N_SRC → EXC, code 10; acc_size 11, or half with addr[0]=1, or word with addr[1:0]≠0 → EXC, code 01; else latch src_addr[sel] into addr_out, go REQ. In error cases addr_out still captures the offending address (0 for out-of-range sel).
- REQ: mem_req=1, addr_out held stable regardless of sel/src_addr changes; start ignored. mem_ready=1 → done pulse, IDLE, counter cleared. Counter increments each REQ cycle without mem_ready; reaching TIMEOUT without mem_ready → EXC, code 11, mem_req drops.
- EXC: err=1, err_code held, mem_req=0; start ignored; err_clr → IDLE, err 0, err_code 00. err_clr outside EXC has no effect.
- busy = (state ≠ IDLE).
- Counter width $clog2(TIMEOUT+1); never wraps.

## Timing
- start sampled at edge t → addr_out/mem_req valid after edge t, i.e. in cycle t+1.
- Earliest mem_ready seen in cycle t+1 → done high in cycle t+2, mem_req low in t+2. Minimum transfer: 2 cycles start-to-done.
- mem_ready in the same cycle as timeout expiry: ready wins (done, no error).
- mem_ready while not in REQ: ignored.
- Error entry: err high the cycle after the offending start; start and err_clr never coincide meaningfully (err_clr only acts in EXC).
- reset_n low at any time (including mid-REQ): all outputs to reset values immediately, no done pulse.
- Back-to-back: start may be asserted in the cycle done is high; it is accepted (state is IDLE then).

## Structure
- Shared package: state enum (IDLE, REQ, EXC), err_code constants, acc_size encodings.
- One natural sub-module: mem_align_chk (combinational: addr low bits + acc_size → misaligned flag), reusable by the load/store unit.

## Test plan
- Reset then start, sel=1, src1=0x0000_0040, word, mem_ready at t+1 → addr_out=0x40, mem_req high 1 cycle, done in t+2, busy low after.
- start, word, addr 0x0000_0042 → err=1, err_code=01, mem_req never high; err_clr → IDLE, err 0.
- N_SRC=3, start with sel=3 → err_code=10, addr_out=0.
- TIMEOUT=4, mem_ready held low → mem_req high 4 cycles, then err_code=11; repeat with mem_ready on 4th cycle → done, no error.
- During REQ change sel and src_addr, pulse start → addr_out unchanged, second start ignored.
- reset_n low mid-REQ → mem_req and busy 0 asynchronously, no done; normal transfer afterwards.
